downsampler_h_0_fp16: RTL
=========================

DOWNSAMPLER_H_0_FP16 -- requirements
Module: downsampler_h_0_fp16

Interface
REQ-001 The block SHALL have parameter EXP_WIDTH, default 5, floating-point exponent width.
REQ-002 The block SHALL have parameter FRAC_WIDTH, default 10, floating-point fraction width; FP width = 1+EXP_WIDTH+FRAC_WIDTH (16).
REQ-003 The block SHALL have parameter IMAGE_WIDTH, default 640, input columns per row; it must be even and >= 4.
REQ-004 The block SHALL have port clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port data_i  input  16  fp16 input pixel.
REQ-007 The block SHALL have port col_i  input  16  column of data_i.
REQ-008 The block SHALL have port row_i  input  16  row of data_i.
REQ-009 The block SHALL have port valid_i  input  1  data_i/col_i/row_i qualifier, one pixel per asserted cycle.
REQ-010 The block SHALL have port data_o  output  16  fp16 filtered, decimated pixel.
REQ-011 The block SHALL have port col_o  output  16  output column (input center column / 2).
REQ-012 The block SHALL have port row_o  output  16  output row (equal to input row).
REQ-013 The block SHALL have port valid_o  output  1  output qualifier.
REQ-014 The block SHALL have port err_o  output  1  sticky column-sequence error flag.

Function
REQ-015 The block SHALL compute out[k] = 0.25*p[2k-1] + 0.5*p[2k] + 0.25*p[2k+1] per row, k = 0..IMAGE_WIDTH/2-1, with p[-1] replaced by p[0] (left-edge replicate).
REQ-016 The block SHALL perform the weighted sum by instantiating convolution_floating_point (WINDOW_WIDTH 3, WINDOW_HEIGHT 1, SAME_SIGN 0) with kernel_i constant {0x3400, 0x3800, 0x3400}.
REQ-017 The block SHALL hold the two most recent accepted pixels (prev1 = col-1, prev2 = col-2) in registers updated only on accepted valid_i.
REQ-018 The block SHALL issue a window to the convolution only on accepted pixels with odd col_i; window = {prev2 or prev1 if col_i==1, prev1, data_i}; even-column pixels issue nothing.
REQ-019 The issued window SHALL be registered one cycle before the convolution, with col = (col_i-1)>>1 and row = row_i carried alongside.
REQ-020 Total latency valid_i (odd column) -> valid_o SHALL be 1 + the convolution_floating_point latency, fixed, with no stalls; output rate is at most one pixel per two input pixels.
REQ-021 The block SHALL run a sequence checker FSM with states EXPECT_ROW_START (expect col_i==0) and IN_ROW (expect col_i == previous col+1).
REQ-022 EXPECT_ROW_START: valid_i with col_i==0 -> IN_ROW; any other col_i -> set err_o, drop pixel, stay.
REQ-023 IN_ROW: valid_i with col_i == expected -> accept; if col_i == IMAGE_WIDTH-1 -> EXPECT_ROW_START after accept.
REQ-024 IN_ROW: valid_i with col_i != expected -> set err_o, drop pixel, discard prev1/prev2, go to EXPECT_ROW_START; a col_i==0 pixel in that same cycle SHALL be accepted as a new row start (resync) and the FSM goes to IN_ROW.
REQ-025 Dropped pixels SHALL never produce an output; windows already in the convolution pipeline SHALL complete normally.
REQ-026 Gaps (valid_i low) of any length inside a row SHALL be tolerated with no effect on results.
REQ-027 err_o SHALL remain set until rst_i.

Reset
REQ-028 On rst_i high at a clock edge: FSM -> EXPECT_ROW_START, prev1/prev2 -> 0, window register valid -> 0, err_o -> 0, and convolution pipeline valids cleared.
REQ-029 While rst_i is high and for the first cycle after, valid_o SHALL be 0; data_o/col_o/row_o SHALL be 0 during reset.
REQ-030 Reset mid-row SHALL discard all in-flight windows; the next accepted pixel must have col_i==0.

Verification
REQ-031 Flat row: IMAGE_WIDTH=8, all pixels 0x3C00 -> four outputs 0x3C00, col_o 0,1,2,3, row_o = input row.
REQ-032 Ramp row: pixels 0x0000,0x3C00,0x4000,0x4200,... -> out[0]=0x3400 (0.25, left replicate), out[1]=0x4000 (2.0), valid_o exactly 1+conv latency after col 1 and col 3.
REQ-033 Gapped input: same ramp with valid_i low every other cycle -> identical data_o/col_o sequence as REQ-032.
REQ-034 Sequence error: cols 0,1,2,4 -> err_o set on the col-4 cycle, only out[0] produced; following row starting at col 0 filtered correctly, err_o still 1.
REQ-035 Reset mid-row: assert rst_i after col 3 accepted with window in flight -> no valid_o afterwards, err_o 0; new row at col 0 produces correct outputs.

Source files
------------

// File: rtl/downsampler_h_0_fp16.sv
// Horizontal 2:1 fp16 downsampler: [0.25 0.5 0.25] filter on odd columns with a column-sequence checker.
// Includes the floating-point window convolution it drives.

module convolution_floating_point #(
    parameter int unsigned EXP_WIDTH     = 5,
    parameter int unsigned FRAC_WIDTH    = 10,
    parameter int unsigned WINDOW_WIDTH  = 3,
    parameter int unsigned WINDOW_HEIGHT = 1,
    parameter int unsigned SAME_SIGN     = 0
) (
    input  logic                                                          clk_i,
    input  logic                                                          rst_i,
    input  logic                                                          valid_i,
    input  logic [WINDOW_WIDTH*WINDOW_HEIGHT*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] data_i,
    input  logic [WINDOW_WIDTH*WINDOW_HEIGHT*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] kernel_i,
    output logic                                                          valid_o,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]                                 data_o
);
    localparam int unsigned FP_W   = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int unsigned MAG_W  = FP_W - 1;
    localparam int unsigned N      = WINDOW_WIDTH * WINDOW_HEIGHT;
    localparam int unsigned MANT_W = FRAC_WIDTH + 1;
    localparam int unsigned SH_W   = EXP_WIDTH + 1;
    localparam int          EXP_MAX = (1 << EXP_WIDTH) - 1;
    localparam int          BIAS    = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int unsigned MAX_SH = 2 * (EXP_MAX - 1) - 2;
    localparam int unsigned ACC_W  = 2 * MANT_W + MAX_SH + $clog2(N) + 2;
    // Biased exponent of the accumulator = leading-one index - P_OFS; subnormals use a fixed shift.
    localparam int          P_OFS  = BIAS + 2 * FRAC_WIDTH - 2;
    localparam int          SUB_SH = BIAS + FRAC_WIDTH - 1;

    logic signed [ACC_W-1:0] terms_c [N];
    logic signed [ACC_W-1:0] terms_q [N];
    logic                    valid_q;

    logic [FP_W-1:0]      op_a, op_k;
    logic [EXP_WIDTH-1:0] ea, ek;
    logic [SH_W-1:0]      psh;
    logic [ACC_W-1:0]     pmag;
    logic                 pneg;

    // Exact products placed in a fixed-point accumulator (inf/NaN operands not supported).
    always_comb begin
        op_a = '0;
        op_k = '0;
        ea   = '0;
        ek   = '0;
        psh  = '0;
        pmag = '0;
        pneg = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_a = data_i[i*FP_W +: FP_W];
            op_k = kernel_i[i*FP_W +: FP_W];
            ea   = op_a[FP_W-2 -: EXP_WIDTH];
            ek   = op_k[FP_W-2 -: EXP_WIDTH];
            psh  = SH_W'((ea == '0) ? EXP_WIDTH'(1) : ea) + SH_W'((ek == '0) ? EXP_WIDTH'(1) : ek) - SH_W'(2);
            pmag = (ACC_W'({ea != '0, op_a[FRAC_WIDTH-1:0]}) * ACC_W'({ek != '0, op_k[FRAC_WIDTH-1:0]})) << psh;
            // SAME_SIGN != 0: caller guarantees every product is non-negative
            pneg = (SAME_SIGN != 0) ? 1'b0 : (op_a[FP_W-1] ^ op_k[FP_W-1]);
            terms_c[i] = pneg ? -$signed(pmag) : $signed(pmag);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            for (int i = 0; i < N; i++) terms_q[i] <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) terms_q <= terms_c;
        end
    end

    logic signed [ACC_W-1:0] sum_c;
    logic [ACC_W-1:0]        abs_c, low_c;
    logic                    sign_c, guard_c, sticky_c, rnd_c;
    logic [FRAC_WIDTH-1:0]   frac_c;
    logic [FP_W-1:0]         result_c;
    int                      lead_c, exp_c, sh_c;

    // Sum, normalise and round to nearest even.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N; i++) sum_c = sum_c + terms_q[i];
        sign_c = sum_c[ACC_W-1];
        abs_c  = sign_c ? ACC_W'(-sum_c) : ACC_W'(sum_c);
        lead_c = 0;
        for (int b = 0; b < ACC_W; b++) if (abs_c[b]) lead_c = b;
        if (lead_c > P_OFS) begin
            exp_c = lead_c - P_OFS;
            sh_c  = lead_c - FRAC_WIDTH;
        end else begin
            exp_c = 0;
            sh_c  = SUB_SH;
        end
        frac_c   = FRAC_WIDTH'(abs_c >> sh_c);
        low_c    = abs_c >> (sh_c - 1);
        guard_c  = low_c[0];
        sticky_c = |(abs_c & ((ACC_W'(1) << (sh_c - 1)) - ACC_W'(1)));
        rnd_c    = guard_c & (sticky_c | frac_c[0]);
        if (exp_c >= EXP_MAX) result_c = {sign_c, EXP_WIDTH'(EXP_MAX), FRAC_WIDTH'(0)};
        else result_c = {sign_c, MAG_W'({EXP_WIDTH'(exp_c), frac_c}) + MAG_W'(rnd_c)};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= valid_q;
            if (valid_q) data_o <= result_c;
        end
    end
endmodule

module downsampler_h_0_fp16 #(
    parameter int unsigned EXP_WIDTH   = 5,
    parameter int unsigned FRAC_WIDTH  = 10,
    parameter int unsigned IMAGE_WIDTH = 640
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] data_i,
    input  logic [15:0]                  col_i,
    input  logic [15:0]                  row_i,
    input  logic                         valid_i,
    output logic [EXP_WIDTH+FRAC_WIDTH:0] data_o,
    output logic [15:0]                  col_o,
    output logic [15:0]                  row_o,
    output logic                         valid_o,
    output logic                         err_o
);
    localparam int unsigned FP_W    = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int unsigned COORD_W = 16;
    localparam int unsigned WIN_W   = 3 * FP_W;
    localparam logic [WIN_W-1:0]   KERNEL   = WIN_W'(48'h3400_3800_3400);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMAGE_WIDTH - 1);

    typedef enum logic {EXPECT_ROW_START, IN_ROW} state_t;
    state_t state_q, state_c;

    logic               accept_c, err_c, flush_c;
    logic [COORD_W-1:0] exp_col_q;
    logic [FP_W-1:0]    prev1_q, prev2_q;
    logic [WIN_W-1:0]   win_q;
    logic               win_valid_q, v1_q;
    logic [COORD_W-1:0] win_col_q, win_row_q, col1_q, row1_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= EXPECT_ROW_START;
        else       state_q <= state_c;
    end

    // Column-sequence checker: decides accept / drop / flush for each valid pixel.
    always_comb begin
        state_c  = state_q;
        accept_c = 1'b0;
        err_c    = 1'b0;
        flush_c  = 1'b0;
        if (valid_i) begin
            case (state_q)
                EXPECT_ROW_START: begin
                    if (col_i == '0) begin
                        accept_c = 1'b1;
                        state_c  = IN_ROW;
                    end else begin
                        err_c = 1'b1;
                    end
                end
                IN_ROW: begin
                    if (col_i == exp_col_q) begin
                        accept_c = 1'b1;
                        if (col_i == LAST_COL) state_c = EXPECT_ROW_START;
                    end else begin
                        err_c   = 1'b1;
                        flush_c = 1'b1;
                        if (col_i == '0) accept_c = 1'b1;
                        else             state_c  = EXPECT_ROW_START;
                    end
                end
                default: state_c = EXPECT_ROW_START;
            endcase
        end
    end

    // Pixel history, window register and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_col_q   <= '0;
            prev1_q     <= '0;
            prev2_q     <= '0;
            err_o       <= 1'b0;
            win_valid_q <= 1'b0;
            win_q       <= '0;
            win_col_q   <= '0;
            win_row_q   <= '0;
        end else begin
            if (err_c) err_o <= 1'b1;
            if (accept_c) begin
                prev1_q   <= data_i;
                prev2_q   <= flush_c ? '0 : prev1_q;
                exp_col_q <= col_i + COORD_W'(1);
            end else if (flush_c) begin
                prev1_q <= '0;
                prev2_q <= '0;
            end
            win_valid_q <= accept_c & col_i[0];
            if (accept_c && col_i[0]) begin
                // p[2k-1] in the low slot; column 1 replicates p[0] for the left edge
                win_q     <= {data_i, prev1_q, (col_i == COORD_W'(1)) ? prev1_q : prev2_q};
                win_col_q <= (col_i - COORD_W'(1)) >> 1;
                win_row_q <= row_i;
            end
        end
    end

    convolution_floating_point #(
        .EXP_WIDTH    (EXP_WIDTH),
        .FRAC_WIDTH   (FRAC_WIDTH),
        .WINDOW_WIDTH (3),
        .WINDOW_HEIGHT(1),
        .SAME_SIGN    (0)
    ) u_conv (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (win_valid_q),
        .data_i  (win_q),
        .kernel_i(KERNEL),
        .valid_o (valid_o),
        .data_o  (data_o)
    );

    // Coordinates follow the convolution's two register stages.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q   <= 1'b0;
            col1_q <= '0;
            row1_q <= '0;
            col_o  <= '0;
            row_o  <= '0;
        end else begin
            v1_q <= win_valid_q;
            if (win_valid_q) begin
                col1_q <= win_col_q;
                row1_q <= win_row_q;
            end
            if (v1_q) begin
                col_o <= col1_q;
                row_o <= row1_q;
            end
        end
    end
endmodule
